// File: rtl/mmio_bridge_pkg.sv
// Shared constants for the MMIO bridge: I/O address, button codes, status layout.
// Pure declarations, no logic or latency.
package mmio_bridge_pkg;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

    typedef enum logic [1:0] {
        BTN_NONE  = 2'd0,
        BTN_START = 2'd1,
        BTN_LEFT  = 2'd2,
        BTN_RIGHT = 2'd3
    } btn_code_e;

    // Bit positions inside the pending/level vectors and the status word.
    localparam int PEND_RIGHT    = 0;
    localparam int PEND_LEFT     = 1;
    localparam int PEND_START    = 2;
    localparam int STAT_CODE_LSB = 0;
    localparam int STAT_LVL_LSB  = 2;

    function automatic btn_code_e btn_code(input logic [2:0] pend);
        btn_code_e code;
        code = BTN_NONE;
        if (pend[PEND_START]) begin
            code = BTN_START;
        end else if (pend[PEND_LEFT]) begin
            code = BTN_LEFT;
        end else if (pend[PEND_RIGHT]) begin
            code = BTN_RIGHT;
        end
        return code;
    endfunction

endpackage

// File: rtl/mmio_bridge_button_debounce.sv
// One button: 2-flop synchroniser, stable-level debounce counter, press pulse.
// Level change accepted after DEBOUNCE_CYCLES mismatching cycles; no backpressure.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // press rises together with level, so it is a clean single-cycle pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= ~btn_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_2;
                cnt   <= '0;
                press <= sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// CPU-to-memory port B bridge with a button status register at IO_ADDR.
// Loads return after 1 cycle from either source; no backpressure, stores pass straight through.
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int               WIDTH           = 16,
    parameter logic [WIDTH-1:0] IO_ADDR         = WIDTH'(IO_ADDR_DEFAULT),
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter int               CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_n,
    input  logic             left_n,
    input  logic             right_n,
    input  logic             cpu_re,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_q
);

    logic             io_hit;
    logic             io_rd;
    logic             io_wr;
    logic [2:0]       lvl;
    logic [2:0]       press;
    logic [2:0]       pend;
    logic [2:0]       pend_clr;
    btn_code_e        code;
    logic [WIDTH-1:0] status;
    logic             io_sel_q;
    logic [WIDTH-1:0] io_data_q;

    assign io_hit    = (cpu_addr == IO_ADDR);
    assign io_rd     = cpu_re & io_hit;
    assign io_wr     = cpu_we & io_hit;
    assign mem_addr  = cpu_addr;
    assign mem_wdata = cpu_wdata;
    assign mem_we    = cpu_we & ~io_hit;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_start (
        .clk   (clk),
        .reset (reset),
        .btn_n (start_n),
        .level (lvl[PEND_START]),
        .press (press[PEND_START])
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_left (
        .clk   (clk),
        .reset (reset),
        .btn_n (left_n),
        .level (lvl[PEND_LEFT]),
        .press (press[PEND_LEFT])
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_right (
        .clk   (clk),
        .reset (reset),
        .btn_n (right_n),
        .level (lvl[PEND_RIGHT]),
        .press (press[PEND_RIGHT])
    );

    assign code = btn_code(pend);

    always_comb begin
        status = '0;
        status[STAT_CODE_LSB +: 2] = code;
        status[STAT_LVL_LSB +: 3]  = {lvl[PEND_RIGHT], lvl[PEND_LEFT], lvl[PEND_START]};
    end

    // A read clears only the event it reported; a write with bit 0 set clears everything.
    always_comb begin
        pend_clr = '0;
        if (io_rd) begin
            case (code)
                BTN_START: pend_clr[PEND_START] = 1'b1;
                BTN_LEFT:  pend_clr[PEND_LEFT]  = 1'b1;
                BTN_RIGHT: pend_clr[PEND_RIGHT] = 1'b1;
                default:   pend_clr = '0;
            endcase
        end
        if (io_wr && cpu_wdata[0]) begin
            pend_clr = '1;
        end
    end

    // New presses are OR-ed in after the clear so a coincident press is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend      <= '0;
            io_sel_q  <= 1'b0;
            io_data_q <= '0;
        end else begin
            pend      <= (pend & ~pend_clr) | press;
            io_sel_q  <= io_rd;
            io_data_q <= status;
        end
    end

    assign cpu_rdata = io_sel_q ? io_data_q : mem_q;

endmodule

// File: tb/tb_mmio_bridge.sv
`timescale 1ns/1ps
module tb_mmio_bridge;

    localparam int          D  = 4;
    localparam logic [15:0] IO = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_n = 1'b1;
    logic        left_n = 1'b1;
    logic        right_n = 1'b1;
    logic        cpu_re = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_q = '0;

    always #5 clk = ~clk;

    mmio_bridge #(
        .WIDTH           (16),
        .IO_ADDR         (IO),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_n   (start_n),
        .left_n    (left_n),
        .right_n   (right_n),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_q     (mem_q)
    );

    // Memory port B stand-in: 64 words, registered read.
    logic [15:0] ram [64];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
        mem_q <= ram[mem_addr[5:0]];
    end

    typedef struct {
        logic [15:0] exp;
        bit          has_dir;
        logic [15:0] dir;
    } sb_t;

    sb_t         sb [$];
    bit          dir_vld = 1'b0;
    logic [15:0] dir_val = '0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          done = 1'b0;

    // Reference model: buttons indexed 0=start,1=left,2=right; a level flips once the
    // last D samples seen two cycles late all disagree with it.
    initial begin : model
        bit [D:0]    hist [3];
        bit [2:0]    lvl_m;
        bit [2:0]    pend_m;
        bit [2:0]    rose_m;
        bit [2:0]    nxt;
        bit [2:0]    raw;
        logic [15:0] shadow [64];
        bit          io_rd;
        bit          io_wr;
        int          code;
        logic [15:0] st;
        sb_t         e;
        lvl_m = '0; pend_m = '0; rose_m = '0;
        for (int b = 0; b < 3; b++) hist[b] = '0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                lvl_m = '0; pend_m = '0; rose_m = '0;
                for (int b = 0; b < 3; b++) hist[b] = '0;
            end else begin
                io_rd = cpu_re && (cpu_addr == IO);
                io_wr = cpu_we && (cpu_addr == IO);
                code = 0;
                for (int b = 2; b >= 0; b--) if (pend_m[b]) code = b + 1;
                st = 16'(code) | (16'(lvl_m) << 2);
                if (cpu_re) begin
                    e.exp     = io_rd ? st : shadow[cpu_addr[5:0]];
                    e.has_dir = dir_vld;
                    e.dir     = dir_val;
                    sb.push_back(e);
                end
                if (cpu_we && !io_wr) shadow[cpu_addr[5:0]] = cpu_wdata;
                nxt = pend_m;
                if (io_rd && code != 0) nxt[code-1] = 1'b0;
                if (io_wr && cpu_wdata[0]) nxt = '0;
                pend_m = nxt | rose_m;
                raw = {~right_n, ~left_n, ~start_n};
                for (int b = 0; b < 3; b++) begin
                    rose_m[b] = 1'b0;
                    if (hist[b][D:1] == {D{~lvl_m[b]}}) begin
                        lvl_m[b]  = ~lvl_m[b];
                        rose_m[b] = lvl_m[b];
                    end
                    hist[b] = {hist[b][D-1:0], raw[b]};
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    initial begin : monitor
        sb_t e;
        while (!done) begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rdata_model", cpu_rdata, e.exp);
                if (e.has_dir) check("rdata_directed", cpu_rdata, e.dir);
            end
            check("mem_addr", mem_addr, cpu_addr);
            check("mem_wdata", mem_wdata, cpu_wdata);
            check("mem_we", {15'd0, mem_we}, {15'd0, (cpu_we && cpu_addr != IO)});
            if (!reset) check("reset_rdata", cpu_rdata, mem_q);
        end
        check("sb_drain", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    task automatic idle();
        cpu_re = 1'b0; cpu_we = 1'b0; dir_vld = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic op(input bit re, input bit we, input logic [15:0] a, input logic [15:0] d,
                      input bit dv, input logic [15:0] dval);
        cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        dir_vld = dv; dir_val = dval;
        @(negedge clk);
        idle();
    endtask

    task automatic rd_io(input logic [15:0] want);
        op(1'b1, 1'b0, IO, 16'($urandom), 1'b1, want);
    endtask

    task automatic toggle_btn(input int b);
        case (b)
            0:       start_n = ~start_n;
            1:       left_n  = ~left_n;
            default: right_n = ~right_n;
        endcase
    endtask

    initial begin : stim
        int dur [3];
        idle();
        tick(3);
        reset = 1'b1;
        tick(2);
        for (int a = 0; a < 64; a++) op(1'b0, 1'b1, 16'(a), 16'($urandom), 1'b0, 16'h0);

        // pass-through, and a store to the I/O address that must not reach memory
        op(1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0, 16'h0);
        op(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234);
        op(1'b0, 1'b1, IO, 16'h1234, 1'b0, 16'h0);
        tick(2);

        // clean press, then release generates nothing
        start_n = 1'b0; tick(20);
        rd_io(16'h0005); rd_io(16'h0004);
        start_n = 1'b1; tick(20);
        rd_io(16'h0000);

        // glitches shorter than D never register
        left_n = 1'b0; tick(3); left_n = 1'b1; tick(2);
        left_n = 1'b0; tick(3); left_n = 1'b1; tick(8);
        rd_io(16'h0000); rd_io(16'h0000);

        // priority and per-read clear
        right_n = 1'b0; tick(20); left_n = 1'b0; tick(20);
        right_n = 1'b1; left_n = 1'b1; tick(20);
        rd_io(16'h0002); rd_io(16'h0003); rd_io(16'h0000);

        // clear-all, then a press landing on the same edge as the read that clears it
        start_n = 1'b0; left_n = 1'b0; right_n = 1'b0; tick(20);
        start_n = 1'b1; left_n = 1'b1; right_n = 1'b1; tick(20);
        op(1'b0, 1'b1, IO, 16'h0001, 1'b0, 16'h0);
        rd_io(16'h0000);
        start_n = 1'b0; tick(20); start_n = 1'b1; tick(20);
        start_n = 1'b0; tick(D + 2);
        rd_io(16'h0005); rd_io(16'h0005); rd_io(16'h0004);
        start_n = 1'b1; tick(20);

        // reset with a held button and a pending event
        start_n = 1'b0; tick(20);
        reset = 1'b0; tick(1); reset = 1'b1;
        for (int i = 0; i < D + 2; i++) rd_io(16'h0000);
        tick(3);
        rd_io(16'h0005);
        start_n = 1'b1; tick(20);
        rd_io(16'h0000);

        // randomized traffic and bouncy buttons
        for (int b = 0; b < 3; b++) dur[b] = $urandom_range(1, 12);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (dur[b] == 0) begin
                    toggle_btn(b);
                    dur[b] = $urandom_range(1, 12);
                end else begin
                    dur[b]--;
                end
            end
            if (c % 1000 == 999) begin
                idle();
                tick(1);
                reset = 1'b0;
                tick($urandom_range(1, 2));
                reset = 1'b1;
            end else begin
                cpu_re    = ($urandom % 3) == 0;
                cpu_we    = ($urandom % 4) == 0;
                cpu_addr  = (($urandom % 4) == 0) ? IO : 16'($urandom_range(0, 63));
                cpu_wdata = 16'($urandom);
                dir_vld   = 1'b0;
                @(negedge clk);
            end
        end
        idle();
        tick(5);
        done = 1'b1;
    end

endmodule
